spi_master_mode0: RTL and testbench

SPI mode 0 (CPOL=0, CPHA=0) master. It generates SCS0, SCLK and MOSI from the system clock and captures MISO. The block moves frames of 1..2^LEN_W-1 bytes, MSB first. A byte-wide load/valid interface connects it to a local controller; this is the initiator side for the board's SPI slave peripherals.

---
 rtl/spi_master_mode0.sv | 236 +++++++++++++++++++++++
 tb/tb_spi_master_mode0.sv | 375 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_mode0.sv
// SPI mode 0 (CPOL=0, CPHA=0) master for the board's SPI slave peripherals.
// Frames are 1..2^LEN_W-1 bytes, MSB first. Bytes come in over a load/valid
// style interface to the local controller.
//
// Ports:
//   clk       system clock
//   rst       asynchronous active-high reset
//   start     one-cycle frame request, honoured only in IDLE with byte_num != 0
//   byte_num  frame length in bytes, sampled with start
//   tx_data   next byte to send, sampled at each load point
//   tx_load   pulse the cycle after tx_data was captured
//   rx_data   last received byte, held between updates
//   rx_vld    pulse coincident with an rx_data update
//   busy      high from the cycle after an accepted start until done
//   done      pulse at frame completion
//   scs0      chip select, active low
//   sclk      SPI clock, idles low
//   mosi      serial data out
//   miso      serial data in (asynchronous, synchronised internally)
//
// state | meaning
// IDLE  | chip select high, waiting for start
// SETUP | chip select low, first MOSI bit presented, sclk low
// SHIFT | 8*N bits, CLK_DIV cycles low then CLK_DIV cycles high per bit
// HOLD  | sclk low after the last falling edge, chip select still low
// GAP   | chip select high before done/next frame
module spi_master_mode0 #(
  parameter int CLK_DIV  = 4,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2,
  parameter int CS_GAP   = 4,
  parameter int LEN_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] byte_num,
  input  logic [7:0]       tx_data,
  output logic             tx_load,
  output logic [7:0]       rx_data,
  output logic             rx_vld,
  output logic             busy,
  output logic             done,
  output logic             scs0,
  output logic             sclk,
  output logic             mosi,
  input  logic             miso
);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

  localparam int MAX_A = (CLK_DIV > CS_SETUP) ? CLK_DIV : CS_SETUP;
  localparam int MAX_B = (CS_HOLD > CS_GAP) ? CS_HOLD : CS_GAP;
  localparam int MAX_C = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CW    = $clog2(MAX_C + 1);

  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO = '0;
  localparam logic [CW-1:0] DIV_LD   = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] SETUP_LD = CW'(CS_SETUP - 1);
  localparam logic [CW-1:0] HOLD_LD  = CW'(CS_HOLD - 1);
  // The done cycle itself is the last chip-select-high cycle, so GAP lasts
  // CS_GAP-1 cycles and a start in the done cycle still sees CS_GAP high cycles.
  localparam logic [CW-1:0] GAP_LD   = CW'((CS_GAP > 1) ? (CS_GAP - 2) : 0);
  localparam logic [LEN_W-1:0] BYTE_ONE = LEN_W'(1);

  state_t           state, state_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic [2:0]       bit_idx, bit_idx_n;
  logic [LEN_W-1:0] byte_idx, byte_idx_n;
  logic [LEN_W-1:0] num_q, num_n;
  logic [6:0]       tx_sh, tx_sh_n;   // bits still to send after the one on mosi
  logic [6:0]       rx_sh, rx_sh_n;
  logic             miso_m, miso_s;
  logic [7:0]       rx_new;

  logic       tx_load_n, rx_vld_n, busy_n, done_n, scs0_n, sclk_n, mosi_n;
  logic [7:0] rx_data_n;

  assign rx_new = {rx_sh, miso_s};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      miso_m <= 1'b0;
      miso_s <= 1'b0;
    end else begin
      miso_m <= miso;
      miso_s <= miso_m;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      bit_idx  <= '0;
      byte_idx <= '0;
      num_q    <= '0;
      tx_sh    <= '0;
      rx_sh    <= '0;
      tx_load  <= 1'b0;
      rx_vld   <= 1'b0;
      rx_data  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      scs0     <= 1'b1;
      sclk     <= 1'b0;
      mosi     <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      bit_idx  <= bit_idx_n;
      byte_idx <= byte_idx_n;
      num_q    <= num_n;
      tx_sh    <= tx_sh_n;
      rx_sh    <= rx_sh_n;
      tx_load  <= tx_load_n;
      rx_vld   <= rx_vld_n;
      rx_data  <= rx_data_n;
      busy     <= busy_n;
      done     <= done_n;
      scs0     <= scs0_n;
      sclk     <= sclk_n;
      mosi     <= mosi_n;
    end
  end

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    bit_idx_n  = bit_idx;
    byte_idx_n = byte_idx;
    num_n      = num_q;
    tx_sh_n    = tx_sh;
    rx_sh_n    = rx_sh;
    rx_data_n  = rx_data;
    busy_n     = busy;
    scs0_n     = scs0;
    sclk_n     = sclk;
    mosi_n     = mosi;
    tx_load_n  = 1'b0;
    rx_vld_n   = 1'b0;
    done_n     = 1'b0;

    case (state)
      IDLE: begin
        if (start && (byte_num != '0)) begin
          state_n   = SETUP;
          cnt_n     = SETUP_LD;
          num_n     = byte_num;
          tx_sh_n   = tx_data[6:0];
          mosi_n    = tx_data[7];
          scs0_n    = 1'b0;
          busy_n    = 1'b1;
          tx_load_n = 1'b1;
        end
      end

      SETUP: begin
        if (cnt == CNT_ZERO) begin
          state_n    = SHIFT;
          cnt_n      = DIV_LD;
          bit_idx_n  = '0;
          byte_idx_n = '0;
        end else begin
          cnt_n = cnt - CNT_ONE;
        end
      end

      SHIFT: begin
        if (cnt != CNT_ZERO) begin
          cnt_n = cnt - CNT_ONE;
        end else if (!sclk) begin
          sclk_n = 1'b1;
          cnt_n  = DIV_LD;
        end else begin
          // Last cycle of the high phase: sample miso, then drop sclk and
          // advance mosi on the same edge.
          sclk_n  = 1'b0;
          cnt_n   = DIV_LD;
          rx_sh_n = rx_new[6:0];
          if (bit_idx == 3'd7) begin
            rx_data_n = rx_new;
            rx_vld_n  = 1'b1;
            bit_idx_n = '0;
            // Compare against the latched length so a full-scale byte_num
            // never relies on the index wrapping.
            if ((byte_idx + BYTE_ONE) == num_q) begin
              state_n = HOLD;
              cnt_n   = HOLD_LD;
            end else begin
              byte_idx_n = byte_idx + BYTE_ONE;
              tx_sh_n    = tx_data[6:0];
              mosi_n     = tx_data[7];
              tx_load_n  = 1'b1;
            end
          end else begin
            bit_idx_n = bit_idx + 3'd1;
            mosi_n    = tx_sh[6];
            tx_sh_n   = {tx_sh[5:0], 1'b0};
          end
        end
      end

      HOLD: begin
        if (cnt == CNT_ZERO) begin
          scs0_n = 1'b1;
          mosi_n = 1'b0;
          if (CS_GAP <= 1) begin
            state_n = IDLE;
            done_n  = 1'b1;
            busy_n  = 1'b0;
          end else begin
            state_n = GAP;
            cnt_n   = GAP_LD;
          end
        end else begin
          cnt_n = cnt - CNT_ONE;
        end
      end

      GAP: begin
        if (cnt == CNT_ZERO) begin
          state_n = IDLE;
          done_n  = 1'b1;
          busy_n  = 1'b0;
        end else begin
          cnt_n = cnt - CNT_ONE;
        end
      end

      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_spi_master_mode0.sv
// Self-checking bench for spi_master_mode0 with default parameters.
// A negedge monitor turns the pin activity into frame-level observations
// (chip-select run lengths, sclk rises, bits seen on mosi at each rise,
// tx_load cycles, received bytes); scenario tasks compare those against
// expectations computed from the frame contents and the timing rules.
`timescale 1ns/1ps
module tb_spi_master_mode0;
  localparam int CLK_DIV  = 4;
  localparam int CS_SETUP = 2;
  localparam int CS_HOLD  = 2;
  localparam int CS_GAP   = 4;
  localparam int LEN_W    = 8;
  localparam int BIT_CYC  = 2 * CLK_DIV;
  localparam int BYTE_CYC = 16 * CLK_DIV;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             start = 1'b0;
  logic [LEN_W-1:0] byte_num = '0;
  logic [7:0]       tx_data = 8'h00;
  logic             tx_load, rx_vld, busy, done, scs0, sclk, mosi, miso;
  logic [7:0]       rx_data;
  logic             loop_en = 1'b1;
  logic             mval = 1'b0;

  assign miso = loop_en ? mosi : mval;

  always #5 clk = ~clk;

  spi_master_mode0 #(
    .CLK_DIV(CLK_DIV), .CS_SETUP(CS_SETUP), .CS_HOLD(CS_HOLD),
    .CS_GAP(CS_GAP), .LEN_W(LEN_W)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .byte_num(byte_num),
    .tx_data(tx_data), .tx_load(tx_load), .rx_data(rx_data),
    .rx_vld(rx_vld), .busy(busy), .done(done), .scs0(scs0),
    .sclk(sclk), .mosi(mosi), .miso(miso)
  );

  int checks = 0;
  int errors = 0;

  // ---------------- monitor ----------------
  int cyc = 0;
  int lo_run = 0, hi_run = 0, lo_last = 0, hi_last = 0, lo_runs = 0;
  int sh_run = 0, rises = 0, bad_high = 0, mosi_bad = 0;
  int dones = 0, done_busy = 0;
  logic scs0_p = 1'b1, sclk_p = 1'b0, mosi_p = 1'b0;
  logic       mbits[$];
  int         txl_q[$];
  logic [7:0] rx_q[$];

  initial forever begin
    @(negedge clk);
    if (scs0 === 1'b0) lo_run++;
    else if (scs0_p === 1'b0) begin lo_last = lo_run; lo_runs++; lo_run = 0; end
    if (scs0 === 1'b1) hi_run++;
    else if (scs0_p === 1'b1) begin hi_last = hi_run; hi_run = 0; end
    if (sclk === 1'b1) begin
      sh_run++;
      if (sclk_p !== 1'b1) begin rises++; mbits.push_back(mosi); end
    end else if (sclk_p === 1'b1) begin
      if (sh_run != CLK_DIV) bad_high++;
      sh_run = 0;
    end
    // mosi may move only with a falling sclk, at frame start, or to 0 when
    // chip select releases
    if (mosi !== mosi_p && !(sclk_p && !sclk) && !(scs0_p && !scs0) &&
        !(!scs0_p && scs0 && !mosi)) mosi_bad++;
    if (tx_load === 1'b1) txl_q.push_back(cyc);
    if (rx_vld === 1'b1) rx_q.push_back(rx_data);
    if (done === 1'b1) begin dones++; if (busy !== 1'b0) done_busy++; end
    scs0_p = scs0; sclk_p = sclk; mosi_p = mosi;
    cyc++;
  end

  // ---------------- controller side: advance tx_data on tx_load ----------------
  logic [7:0] feed_q[$];
  logic [7:0] fb[$];

  initial forever begin
    @(negedge clk);
    #2;
    if (tx_load === 1'b1 && feed_q.size() > 0) void'(feed_q.pop_front());
    tx_data = (feed_q.size() > 0) ? feed_q[0] : 8'h00;
  end

  // ---------------- scenarios ----------------
  task automatic test_reset;
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({scs0, sclk, mosi, busy, tx_load, rx_vld, done} !== 7'b1000000 || rx_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_values: got scs0=%b sclk=%b mosi=%b busy=%b txl=%b vld=%b done=%b rx=%h, expected 1000000 rx=00",
               scs0, sclk, mosi, busy, tx_load, rx_vld, done, rx_data);
    end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (scs0 !== 1'b1 || busy !== 1'b0 || sclk !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: got scs0=%b busy=%b sclk=%b, expected 1 0 0", scs0, busy, sclk);
    end
  endtask

  // Runs one frame of fb[0..n-1]. poke_at > 0 pulses start (with a random
  // nonzero byte_num) that many cycles into the frame; it must be ignored.
  task automatic test_frame(input string name, input int n, input int poke_at);
    int s_lo, s_rise, s_bh, s_mb, s_m, s_t, s_r, s_d, s_db, st_cyc, t, e, exp_len, idx, exp_c;
    logic [7:0] b, exp_rx;
    @(negedge clk); #1;
    s_lo = lo_runs; s_rise = rises; s_bh = bad_high; s_mb = mosi_bad;
    s_m = mbits.size(); s_t = txl_q.size(); s_r = rx_q.size();
    s_d = dones; s_db = done_busy;
    for (int i = 0; i < n; i++) feed_q.push_back(fb[i]);
    byte_num = LEN_W'(n);
    start = 1'b1;
    st_cyc = cyc;  // the cycle after the accepting edge carries this index
    @(negedge clk); #1;
    start = 1'b0;
    t = 0;
    while (dones == s_d && t < BYTE_CYC * n + 200) begin
      @(negedge clk); #1;
      t++;
      if (t == poke_at) begin
        start = 1'b1;
        byte_num = LEN_W'($urandom_range(1, 255));
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    checks++;
    if (dones == s_d) begin
      errors++;
      $display("FAIL %s timeout: no done after %0d cycles", name, t);
    end
    exp_len = CS_SETUP + BYTE_CYC * n + CS_HOLD;
    checks++;
    if (lo_runs - s_lo != 1 || lo_last != exp_len) begin
      errors++;
      $display("FAIL %s scs0_low: got %0d runs, last %0d cycles; expected 1 run of %0d",
               name, lo_runs - s_lo, lo_last, exp_len);
    end
    checks++;
    if (rises - s_rise != 8 * n) begin
      errors++;
      $display("FAIL %s sclk_rises: got %0d, expected %0d", name, rises - s_rise, 8 * n);
    end
    checks++;
    if (bad_high != s_bh) begin
      errors++;
      $display("FAIL %s sclk_high_len: %0d high phases not %0d cycles", name, bad_high - s_bh, CLK_DIV);
    end
    e = 0;
    for (int i = 0; i < n; i++) begin
      b = fb[i];
      for (int k = 0; k < 8; k++) begin
        idx = s_m + 8 * i + k;
        if (idx >= mbits.size()) e++;
        else if (mbits[idx] !== b[7 - k]) e++;
      end
    end
    checks++;
    if (e != 0) begin
      errors++;
      $display("FAIL %s mosi_bits: got %0d wrong bits of %0d, expected MSB-first frame data", name, e, 8 * n);
    end
    checks++;
    if (mosi_bad != s_mb) begin
      errors++;
      $display("FAIL %s mosi_timing: got %0d changes off a falling sclk, expected 0", name, mosi_bad - s_mb);
    end
    checks++;
    if (txl_q.size() - s_t != n) begin
      errors++;
      $display("FAIL %s tx_load_count: got %0d, expected %0d", name, txl_q.size() - s_t, n);
    end
    // first load is the cycle right after acceptance; byte k's load follows
    // the falling edge that ends byte k-1, i.e. CS_SETUP + k bytes later
    e = 0;
    for (int i = 0; i < n && s_t + i < txl_q.size(); i++) begin
      exp_c = st_cyc + ((i == 0) ? 0 : CS_SETUP + BYTE_CYC * i);
      if (txl_q[s_t + i] != exp_c) e++;
    end
    checks++;
    if (e != 0) begin
      errors++;
      $display("FAIL %s tx_load_timing: got %0d mistimed pulses (first at %0d, expected %0d)",
               name, e, (txl_q.size() > s_t) ? txl_q[s_t] : -1, st_cyc);
    end
    checks++;
    if (rx_q.size() - s_r != n) begin
      errors++;
      $display("FAIL %s rx_vld_count: got %0d, expected %0d", name, rx_q.size() - s_r, n);
    end
    e = 0;
    for (int i = 0; i < n && s_r + i < rx_q.size(); i++) begin
      exp_rx = loop_en ? fb[i] : {8{mval}};
      if (rx_q[s_r + i] !== exp_rx) begin
        if (e == 0) $display("FAIL %s rx_data[%0d]: got %h, expected %h", name, i, rx_q[s_r + i], exp_rx);
        e++;
      end
    end
    checks++;
    if (e != 0) errors++;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (dones - s_d != 1 || done_busy != s_db || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s done: got %0d pulses, %0d with busy high, busy now %b; expected 1, 0, 0",
               name, dones - s_d, done_busy - s_db, busy);
    end
  endtask

  task automatic test_zero_len;
    int s_lo, s_t, s_d;
    logic busy_seen;
    @(negedge clk); #1;
    s_lo = lo_runs; s_t = txl_q.size(); s_d = dones;
    byte_num = '0;
    start = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
    busy_seen = 1'b0;
    repeat (20) begin
      @(negedge clk); #1;
      if (busy !== 1'b0 || scs0 !== 1'b1) busy_seen = 1'b1;
    end
    checks++;
    if (busy_seen || lo_runs != s_lo || txl_q.size() != s_t || dones != s_d) begin
      errors++;
      $display("FAIL zero_len_start: got busy/scs0 activity=%b, %0d frames, %0d tx_load, %0d done; expected none",
               busy_seen, lo_runs - s_lo, txl_q.size() - s_t, dones - s_d);
    end
  endtask

  task automatic test_back_to_back;
    int n1, n2, t, s_lo, s_d, s_t, s_r, e;
    n1 = $urandom_range(1, 3);
    n2 = $urandom_range(1, 3);
    fb.delete();
    for (int i = 0; i < n1 + n2; i++) fb.push_back(8'($urandom_range(0, 255)));
    loop_en = 1'b1;
    @(negedge clk); #1;
    s_lo = lo_runs; s_d = dones; s_t = txl_q.size(); s_r = rx_q.size();
    for (int i = 0; i < n1 + n2; i++) feed_q.push_back(fb[i]);
    byte_num = LEN_W'(n1);
    start = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
    t = 0;
    while (dones == s_d && t < BYTE_CYC * n1 + 200) begin @(negedge clk); #1; t++; end
    // now inside the done cycle: request the next frame
    byte_num = LEN_W'(n2);
    start = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
    t = 0;
    while (dones == s_d + 1 && t < BYTE_CYC * n2 + 200) begin @(negedge clk); #1; t++; end
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (dones - s_d != 2 || lo_runs - s_lo != 2) begin
      errors++;
      $display("FAIL b2b_frames: got %0d done, %0d scs0 low runs; expected 2 and 2", dones - s_d, lo_runs - s_lo);
    end
    checks++;
    if (hi_last != CS_GAP) begin
      errors++;
      $display("FAIL b2b_gap: got scs0 high %0d cycles between frames, expected %0d", hi_last, CS_GAP);
    end
    checks++;
    if (lo_last != CS_SETUP + BYTE_CYC * n2 + CS_HOLD || txl_q.size() - s_t != n1 + n2) begin
      errors++;
      $display("FAIL b2b_second: got low %0d cycles, %0d tx_load; expected %0d, %0d",
               lo_last, txl_q.size() - s_t, CS_SETUP + BYTE_CYC * n2 + CS_HOLD, n1 + n2);
    end
    e = 0;
    for (int i = 0; i < n1 + n2; i++)
      if (s_r + i >= rx_q.size() || rx_q[s_r + i] !== fb[i]) e++;
    checks++;
    if (e != 0 || rx_q.size() - s_r != n1 + n2) begin
      errors++;
      $display("FAIL b2b_rx: got %0d bytes with %0d wrong, expected %0d correct", rx_q.size() - s_r, e, n1 + n2);
    end
  endtask

  task automatic test_async_reset;
    int s_rise, s_d, t;
    fb.delete();
    fb.push_back(8'($urandom_range(1, 255)));
    loop_en = 1'b1;
    @(negedge clk); #1;
    s_rise = rises; s_d = dones;
    feed_q.push_back(fb[0]);
    byte_num = LEN_W'(1);
    start = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
    t = 0;
    while (rises < s_rise + 3 && t < 200) begin @(negedge clk); #1; t++; end
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    checks++;
    if (scs0 !== 1'b1 || sclk !== 1'b0 || mosi !== 1'b0 || busy !== 1'b0 || rx_data !== 8'h00) begin
      errors++;
      $display("FAIL async_reset: got scs0=%b sclk=%b mosi=%b busy=%b rx=%h, expected 1 0 0 0 00",
               scs0, sclk, mosi, busy, rx_data);
    end
    @(negedge clk); #1;
    rst = 1'b0;
    repeat (20) @(negedge clk);
    #1;
    checks++;
    if (dones != s_d || scs0 !== 1'b1) begin
      errors++;
      $display("FAIL async_reset_no_done: got %0d done pulses, scs0=%b; expected 0, 1", dones - s_d, scs0);
    end
    fb[0] = 8'($urandom_range(0, 255));
    test_frame("after_reset", 1, 0);
  endtask

  initial begin
    test_reset();

    loop_en = 1'b1;
    fb = '{8'hA5};
    test_frame("single_a5", 1, 0);

    fb = '{8'h01, 8'h80, 8'hFF};
    test_frame("three_byte", 3, 0);

    loop_en = 1'b0;
    mval = 1'b1;
    fb = '{8'($urandom_range(0, 255)), 8'($urandom_range(0, 255))};
    test_frame("miso_high", 2, 0);

    loop_en = 1'b1;
    test_zero_len();
    fb = '{8'($urandom_range(0, 255)), 8'($urandom_range(0, 255))};
    test_frame("start_in_shift", 2, 70);
    fb = '{8'($urandom_range(0, 255))};
    test_frame("start_in_gap", 1, 68);

    test_back_to_back();

    repeat (6) begin
      int n;
      n = $urandom_range(1, 4);
      loop_en = 1'($urandom_range(0, 1));
      mval = 1'($urandom_range(0, 1));
      fb.delete();
      for (int i = 0; i < n; i++) fb.push_back(8'($urandom_range(0, 255)));
      test_frame("random", n, 0);
    end

    loop_en = 1'b1;
    fb.delete();
    for (int i = 0; i < 255; i++) fb.push_back(8'($urandom_range(0, 255)));
    test_frame("max_len", 255, 0);

    test_async_reset();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
